pipeline_ctrl: RTL and testbench

Pipeline control sequencer for the 5-stage core. It consumes the load-use stall request from hazard detection, the EX-stage branch resolution and the data-memory ready handshake. It drives the write enables, flushes and bubble injects for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. A small FSM handles multi-cycle data-memory waits with a timeout watchdog and enforces event priority.

---
 rtl/pipeline_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline control sequencer: stall/flush/bubble steering plus a data-memory wait FSM with watchdog.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_stall,
  input  logic             branch_taken_ex,
  input  logic             mem_req_mem,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_we,
  output logic             id_ex_bubble,
  output logic             ex_mem_we,
  output logic             mem_wb_bubble,
  output logic             mem_timeout,
`ifdef PIPE_CTRL_PERF_EN
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] mem_wait_cycles,
`endif
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_TIMEOUT  = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_bad_param
    $error("pipeline_ctrl: MEM_TIMEOUT must be 2..255 and CNT_W >= 1");
  end

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] wait_inc_s;
  logic       mem_timeout_q;
  logic       frozen_s;
  logic       redirect_s;
  logic       stall_s;

  // Next-state logic; the counter holds the number of frozen cycles already spent on this access.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    frozen_s   = 1'b0;
    wait_inc_s = wait_cnt_q + 8'd1;
    case (state_q)
      ST_RUN: begin
        if (mem_req_mem && !mem_ready) begin
          frozen_s   = 1'b1;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_ready) begin
          frozen_s   = 1'b1;
          wait_cnt_d = wait_inc_s;
          if (wait_inc_s == TIMEOUT_C) begin
            state_d = ST_TIMEOUT;
          end else begin
            state_d = ST_MEM_WAIT;
          end
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end
      end
      ST_TIMEOUT: begin
        state_d    = ST_RUN;
        wait_cnt_d = 8'd0;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  assign redirect_s = !rst && !frozen_s && branch_taken_ex;
  assign stall_s    = !rst && !frozen_s && !branch_taken_ex && hazard_stall;

  // Control outputs by priority: reset, memory freeze, branch redirect, load-use stall, normal.
  always_comb begin
    pc_we         = 1'b1;
    pc_sel        = 1'b0;
    if_id_we      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_we      = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_we     = 1'b1;
    mem_wb_bubble = 1'b0;
    if (rst) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_ex_we      = 1'b0;
      ex_mem_we     = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (frozen_s) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_ex_we      = 1'b0;
      ex_mem_we     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (redirect_s) begin
      pc_sel       = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (stall_s) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_bubble = 1'b1;
    end else begin
      pc_sel = 1'b0;
    end
  end

  // State, wait counter and sticky watchdog flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (state_q == ST_TIMEOUT) begin
        mem_timeout_q <= 1'b1;
      end
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign state_o     = state_q;

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, wait_cyc_q;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
      wait_cyc_q  <= {CNT_W{1'b0}};
    end else begin
      if (stall_s && stall_cnt_q != CNT_MAX) begin
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      end
      if (redirect_s && flush_cnt_q != CNT_MAX) begin
        flush_cnt_q <= flush_cnt_q + CNT_ONE;
      end
      if (frozen_s && wait_cyc_q != CNT_MAX) begin
        wait_cyc_q <= wait_cyc_q + CNT_ONE;
      end
    end
  end

  assign stall_cycles    = stall_cnt_q;
  assign flush_count     = flush_cnt_q;
  assign mem_wait_cycles = wait_cyc_q;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a frozen-cycle-counting model.
module tb_pipeline_ctrl;
  localparam int TMO   = 4;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1, hazard_stall = 1'b0, branch_taken_ex = 1'b0;
  logic mem_req_mem = 1'b0, mem_ready = 1'b0;
  logic pc_we, pc_sel, if_id_we, if_id_flush, id_ex_we, id_ex_bubble;
  logic ex_mem_we, mem_wb_bubble, mem_timeout;
  logic [1:0] state_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cycles, flush_count, mem_wait_cycles;
`endif

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  pipeline_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .branch_taken_ex(branch_taken_ex),
    .mem_req_mem(mem_req_mem), .mem_ready(mem_ready),
    .pc_we(pc_we), .pc_sel(pc_sel), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_we(id_ex_we), .id_ex_bubble(id_ex_bubble), .ex_mem_we(ex_mem_we),
    .mem_wb_bubble(mem_wb_bubble), .mem_timeout(mem_timeout),
`ifdef PIPE_CTRL_PERF_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count), .mem_wait_cycles(mem_wait_cycles),
`endif
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Behavioural model: counts frozen cycles of the current access.
  bit in_wait = 0, release_pending = 0, sticky = 0;
  int frozen_run = 0;
  longint m_stall = 0, m_flush = 0, m_wait = 0;

  always @(negedge clk) begin
    bit frozen;
    logic [1:0] exp_state;
    logic [10:0] exp_v, act_v;
    cycle++;
    if (release_pending) begin
      frozen = 0; exp_state = 2'd2;
    end else if (in_wait) begin
      frozen = !mem_ready; exp_state = 2'd1;
    end else begin
      frozen = mem_req_mem && !mem_ready; exp_state = 2'd0;
    end
    // order: pc_we pc_sel if_id_we if_id_flush id_ex_we id_ex_bubble ex_mem_we mem_wb_bubble
    if (rst)                  exp_v[10:3] = 8'b0001_0101;
    else if (frozen)          exp_v[10:3] = 8'b0000_0001;
    else if (branch_taken_ex) exp_v[10:3] = 8'b1111_1110;
    else if (hazard_stall)    exp_v[10:3] = 8'b0000_1110;
    else                      exp_v[10:3] = 8'b1010_1010;
    exp_v[2]   = sticky;
    exp_v[1:0] = exp_state;
    act_v = {pc_we, pc_sel, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we,
             mem_wb_bubble, mem_timeout, state_o};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL outputs cycle %0d: got %b expected %b", cycle, act_v, exp_v);
    end
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    if (stall_cycles !== CNT_W'(m_stall) || flush_count !== CNT_W'(m_flush) ||
        mem_wait_cycles !== CNT_W'(m_wait)) begin
      errors++;
      $display("FAIL counters cycle %0d: got %0d/%0d/%0d expected %0d/%0d/%0d", cycle,
               stall_cycles, flush_count, mem_wait_cycles, m_stall, m_flush, m_wait);
    end
`endif
    // advance the model to the state after the coming rising edge
    if (rst) begin
      in_wait = 0; release_pending = 0; sticky = 0; frozen_run = 0;
      m_stall = 0; m_flush = 0; m_wait = 0;
    end else begin
      if (frozen) m_wait++;
      else if (branch_taken_ex) m_flush++;
      else if (hazard_stall) m_stall++;
      if (release_pending) begin
        release_pending = 0; sticky = 1; in_wait = 0; frozen_run = 0;
      end else if (frozen) begin
        frozen_run++;
        if (frozen_run == TMO) begin
          release_pending = 1; in_wait = 0;
        end else begin
          in_wait = 1;
        end
      end else begin
        in_wait = 0; frozen_run = 0;
      end
    end
  end

  task automatic cyc(input logic r, input logic hs, input logic br, input logic rq, input logic rd);
    @(posedge clk);
    #1;
    rst = r; hazard_stall = hs; branch_taken_ex = br; mem_req_mem = rq; mem_ready = rd;
    #2;
  endtask

  task automatic lit(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    lit("rst_pc_we", pc_we, 0);
    lit("rst_flush", {if_id_flush, id_ex_bubble, mem_wb_bubble}, 7);
    lit("rst_state", state_o, 0);
    lit("rst_timeout", mem_timeout, 0);
    cyc(0, 0, 0, 0, 0);
    lit("normal_we", {pc_we, if_id_we, id_ex_we, ex_mem_we}, 15);
    // load-use stall
    cyc(0, 1, 0, 0, 0);
    lit("stall_we", {pc_we, if_id_we, id_ex_bubble}, 1);
    cyc(0, 0, 0, 0, 0);
    lit("after_stall_pc_we", pc_we, 1);
    lit("model_stall_cnt", m_stall, 1);
`ifdef PIPE_CTRL_PERF_EN
    lit("stall_cycles", stall_cycles, 1);
`endif
    // branch beats stall
    cyc(0, 1, 1, 0, 0);
    lit("br_outs", {pc_sel, if_id_flush, id_ex_bubble, pc_we}, 15);
    cyc(0, 0, 0, 0, 0);
    lit("model_flush_cnt", m_flush, 1);
`ifdef PIPE_CTRL_PERF_EN
    lit("flush_count", flush_count, 1);
    lit("stall_unchanged", stall_cycles, 1);
`endif
    // 3-cycle memory wait
    cyc(0, 0, 0, 1, 0);
    lit("w1_we", {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_bubble}, 1);
    cyc(0, 0, 0, 1, 0);
    lit("w2_state", state_o, 1);
    cyc(0, 0, 0, 1, 0);
    lit("w3_state", state_o, 1);
    lit("w3_pc_we", pc_we, 0);
    cyc(0, 0, 0, 1, 1);
    lit("w4_release", pc_we, 1);
    cyc(0, 0, 0, 0, 0);
    lit("w5_state", state_o, 0);
    lit("model_wait_cnt", m_wait, 3);
`ifdef PIPE_CTRL_PERF_EN
    lit("mem_wait_cycles", mem_wait_cycles, 3);
`endif
    // watchdog
    for (int i = 0; i < TMO; i++) begin
      cyc(0, 0, 0, 1, 0);
      lit("tmo_frozen", pc_we, 0);
    end
    cyc(0, 0, 0, 1, 0);
    lit("tmo_state", state_o, 2);
    lit("tmo_release", pc_we, 1);
    lit("tmo_not_yet", mem_timeout, 0);
    cyc(0, 0, 0, 0, 0);
    lit("tmo_sticky", mem_timeout, 1);
    // branch held during a wait
    cyc(0, 0, 1, 1, 0);
    lit("brw1_pc_sel", pc_sel, 0);
    cyc(0, 0, 1, 1, 0);
    lit("brw2_pc_sel", {pc_sel, state_o}, 1);
    cyc(0, 0, 1, 1, 1);
    lit("brw3_redirect", {pc_sel, pc_we, if_id_flush}, 7);
    cyc(0, 0, 0, 0, 0);
    lit("sticky_hold", mem_timeout, 1);
    // reset during a wait
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    lit("rw_state", state_o, 1);
    cyc(1, 0, 0, 1, 0);
    lit("rw_rst_outs", {if_id_flush, id_ex_bubble, mem_wb_bubble, pc_we, if_id_we, id_ex_we, ex_mem_we}, 112);
    cyc(0, 0, 0, 0, 0);
    lit("rw_state_after", state_o, 0);
    lit("rw_timeout_cleared", mem_timeout, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0));
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
